// File: rtl/ccsds_axis_stream_checker.sv
// AXI-Stream self-checker: compares the DUT output against an expected stream in lockstep,
// counts data/tlast errors, measures first-output latency and optionally throttles both readies.
module ccsds_axis_stream_checker #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned FRAME_LEN   = 1020,
    parameter int unsigned NUM_FRAMES  = 0,
    parameter int unsigned STOP_ON_ERR = 1,
    parameter int unsigned READY_MODE  = 0,
    parameter int unsigned LAT_W       = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stim_fire,
    input  logic [WIDTH-1:0] s_dut_tdata,
    input  logic             s_dut_tvalid,
    input  logic             s_dut_tlast,
    output logic             s_dut_tready,
    input  logic [WIDTH-1:0] s_ref_tdata,
    input  logic             s_ref_tvalid,
    output logic             s_ref_tready,
    output logic [CNT_W-1:0] beat_cnt,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] tlast_err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_got,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [LAT_W-1:0] latency,
    output logic             latency_valid,
    output logic             halted,
    output logic             done,
    output logic             pass
);

    localparam int unsigned BIF_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BIF_W-1:0] LAST_BEAT = BIF_W'(FRAME_LEN - 1);
    localparam logic [LAT_W-1:0] LAT_MAX   = '1;
    localparam logic [15:0]      LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_RUN,
        ST_HALT,
        ST_DONE
    } state_t;

    state_t state, state_next;

    logic [15:0]      lfsr;
    logic [BIF_W-1:0] beat_in_frame;
    logic [LAT_W-1:0] lat_cnt;
    logic             gate;
    logic             active;
    logic             compare;
    logic             exp_last;
    logic             data_err;
    logic             tlast_err;
    logic             any_err;
    logic             frames_met;
    logic [CNT_W-1:0] frame_cnt_inc;
    logic [CNT_W-1:0] err_cnt_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign gate   = (READY_MODE == 0) ? 1'b1 : (lfsr[0] | lfsr[1]);
    assign active = (state == ST_MEASURE) || (state == ST_RUN);

    // Each ready waits on the other side's valid, so both streams always move together.
    assign s_dut_tready = gate & s_ref_tvalid & active;
    assign s_ref_tready = gate & s_dut_tvalid & active;
    assign compare      = gate & s_dut_tvalid & s_ref_tvalid & active;

    assign exp_last      = (beat_in_frame == LAST_BEAT);
    assign data_err      = (s_dut_tdata != s_ref_tdata);
    assign tlast_err     = (s_dut_tlast != exp_last);
    assign any_err       = compare & (data_err | tlast_err);
    assign frame_cnt_inc = sat_inc(frame_cnt);
    assign frames_met    = (NUM_FRAMES != 0) && compare && exp_last
                           && (frame_cnt_inc == CNT_W'(NUM_FRAMES));
    assign err_cnt_next  = any_err ? sat_inc(err_cnt) : err_cnt;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // HALT and DONE are terminal until reset.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (stim_fire) state_next = ST_MEASURE;
            end
            ST_MEASURE, ST_RUN: begin
                if (compare) begin
                    if (any_err && (STOP_ON_ERR != 0)) state_next = ST_HALT;
                    else if (frames_met)               state_next = ST_DONE;
                    else                               state_next = ST_RUN;
                end
            end
            default: state_next = state;
        endcase
    end

    // Fibonacci LFSR, taps 16,14,13,11 in right-shifting form.
    always_ff @(posedge clk) begin
        if (rst) lfsr <= LFSR_SEED;
        else     lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt      <= '0;
            frame_cnt     <= '0;
            err_cnt       <= '0;
            tlast_err_cnt <= '0;
            first_err_idx <= '0;
            first_err_got <= '0;
            first_err_exp <= '0;
            beat_in_frame <= '0;
            lat_cnt       <= '0;
            latency       <= '0;
            latency_valid <= 1'b0;
            halted        <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && stim_fire) begin
                lat_cnt <= '0;
            end else if (state == ST_MEASURE) begin
                lat_cnt <= (lat_cnt == LAT_MAX) ? lat_cnt : lat_cnt + LAT_W'(1);
            end

            if ((state == ST_MEASURE) && compare) begin
                latency       <= (lat_cnt == LAT_MAX) ? lat_cnt : lat_cnt + LAT_W'(1);
                latency_valid <= 1'b1;
            end

            if (compare) begin
                beat_cnt      <= sat_inc(beat_cnt);
                beat_in_frame <= exp_last ? '0 : beat_in_frame + BIF_W'(1);
                if (exp_last) frame_cnt <= frame_cnt_inc;
            end

            // err_cnt never returns to zero, so zero marks "no error captured yet".
            if (any_err) begin
                err_cnt <= err_cnt_next;
                if (tlast_err) tlast_err_cnt <= sat_inc(tlast_err_cnt);
                if (err_cnt == '0) begin
                    first_err_idx <= beat_cnt;
                    first_err_got <= s_dut_tdata;
                    first_err_exp <= s_ref_tdata;
                end
            end

            halted <= (state_next == ST_HALT);
            done   <= (state_next == ST_DONE);
            pass   <= (state_next == ST_DONE) && (err_cnt_next == '0);
        end
    end

endmodule

// File: tb/tb_ccsds_axis_stream_checker.sv
// Scoreboard bench: instance A (READY_MODE=0, STOP_ON_ERR=1, LAT_W=4) and
// instance B (READY_MODE=1, STOP_ON_ERR=0, 250 frames of 4 beats).
module tb_ccsds_axis_stream_checker;

    typedef struct packed {
        logic [31:0] beat;
        logic [31:0] err;
        logic [31:0] tl;
    } exp_t;

    logic clk;
    logic rst_a, rst_b, a_fire, b_fire;
    logic [7:0] a_dd, a_rd, b_dd, b_rd;
    logic a_dv, a_dl, a_rv, b_dv, b_dl, b_rv;
    logic a_dr, a_rr, b_dr, b_rr;
    logic [31:0] a_beat, a_frame, a_err, a_tlerr, a_fidx;
    logic [31:0] b_beat, b_frame, b_err, b_tlerr, b_fidx;
    logic [7:0] a_fgot, a_fexp, b_fgot, b_fexp;
    logic [3:0] a_lat;
    logic [15:0] b_lat;
    logic a_latv, a_halt, a_done, a_pass;
    logic b_latv, b_halt, b_done, b_pass;

    logic [15:0] m_lfsr;
    logic b_gchk = 1'b0;
    logic b_abort = 1'b0;
    exp_t qa[$];
    exp_t qb[$];
    int unsigned n_pass = 0;
    int unsigned n_tot = 0;

    ccsds_axis_stream_checker #(
        .WIDTH(8), .FRAME_LEN(4), .NUM_FRAMES(2), .STOP_ON_ERR(1),
        .READY_MODE(0), .LAT_W(4), .CNT_W(32)
    ) u_a (
        .clk(clk), .rst(rst_a), .stim_fire(a_fire),
        .s_dut_tdata(a_dd), .s_dut_tvalid(a_dv), .s_dut_tlast(a_dl), .s_dut_tready(a_dr),
        .s_ref_tdata(a_rd), .s_ref_tvalid(a_rv), .s_ref_tready(a_rr),
        .beat_cnt(a_beat), .frame_cnt(a_frame), .err_cnt(a_err), .tlast_err_cnt(a_tlerr),
        .first_err_idx(a_fidx), .first_err_got(a_fgot), .first_err_exp(a_fexp),
        .latency(a_lat), .latency_valid(a_latv), .halted(a_halt), .done(a_done), .pass(a_pass)
    );

    ccsds_axis_stream_checker #(
        .WIDTH(8), .FRAME_LEN(4), .NUM_FRAMES(250), .STOP_ON_ERR(0),
        .READY_MODE(1), .LAT_W(16), .CNT_W(32)
    ) u_b (
        .clk(clk), .rst(rst_b), .stim_fire(b_fire),
        .s_dut_tdata(b_dd), .s_dut_tvalid(b_dv), .s_dut_tlast(b_dl), .s_dut_tready(b_dr),
        .s_ref_tdata(b_rd), .s_ref_tvalid(b_rv), .s_ref_tready(b_rr),
        .beat_cnt(b_beat), .frame_cnt(b_frame), .err_cnt(b_err), .tlast_err_cnt(b_tlerr),
        .first_err_idx(b_fidx), .first_err_got(b_fgot), .first_err_exp(b_fexp),
        .latency(b_lat), .latency_valid(b_latv), .halted(b_halt), .done(b_done), .pass(b_pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        else n_pass++;
    endtask

    task automatic fail_note(input string name);
        n_tot++;
        $display("FAIL %s: event not expected / not seen", name);
    endtask

    // Reference LFSR (seed 0xACE1, taps 16,14,13,11), stepping every cycle out of reset.
    always @(posedge clk) begin
        if (rst_b) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    always @(posedge clk) begin
        if (b_gchk && !rst_b) begin
            chk("b_dut_ready_gate", b_dr, (m_lfsr[0] | m_lfsr[1]) & b_rv);
            chk("b_ref_ready_gate", b_rr, (m_lfsr[0] | m_lfsr[1]) & b_dv);
        end
    end

    // Monitors: every transfer pops one expected counter snapshot.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (a_dv && a_dr && !rst_a) begin
                #1;
                if (qa.size() == 0) fail_note("a_unexpected_beat");
                else begin
                    e = qa.pop_front();
                    chk("a_beat_cnt", a_beat, e.beat);
                    chk("a_err_cnt", a_err, e.err);
                    chk("a_tlast_err_cnt", a_tlerr, e.tl);
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (b_dv && b_dr && !rst_b) begin
                #1;
                if (qb.size() == 0) fail_note("b_unexpected_beat");
                else begin
                    e = qb.pop_front();
                    chk("b_beat_cnt", b_beat, e.beat);
                    chk("b_err_cnt", b_err, e.err);
                    chk("b_tlast_err_cnt", b_tlerr, e.tl);
                end
            end
        end
    end

    task automatic a_set(input logic v, input logic [7:0] dd, input logic [7:0] rd, input logic l);
        a_dv = v; a_rv = v; a_dd = dd; a_rd = rd; a_dl = l;
    endtask

    // Reset with valids and stim_fire held high: readies must stay 0 and the fire must be dropped.
    task automatic a_reset();
        a_dv = 1'b1; a_rv = 1'b1; a_fire = 1'b1; rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0; a_fire = 1'b0;
        chk("rst_beat_cnt", a_beat, 0);
        chk("rst_frame_cnt", a_frame, 0);
        chk("rst_err_cnt", a_err, 0);
        chk("rst_tlast_err_cnt", a_tlerr, 0);
        chk("rst_first_err_idx", a_fidx, 0);
        chk("rst_first_err_got", a_fgot, 0);
        chk("rst_first_err_exp", a_fexp, 0);
        chk("rst_latency", a_lat, 0);
        chk("rst_flags", {a_latv, a_halt, a_done, a_pass}, 0);
        chk("rst_readies", {a_dr, a_rr}, 0);
        @(negedge clk);
        chk("rst_fire_ignored_ready", a_dr, 0);
        a_set(1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic a_tests();
        // Clean two-frame run, first valid 5 cycles after stim_fire.
        a_reset();
        a_fire = 1'b1; @(negedge clk); a_fire = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            a_set(1'b1, 8'(i), 8'(i), (i % 4) == 3);
            qa.push_back({32'(i + 1), 32'd0, 32'd0});
            @(negedge clk);
        end
        chk("t1_latency", a_lat, 5);
        chk("t1_latency_valid", a_latv, 1);
        chk("t1_beat_cnt", a_beat, 8);
        chk("t1_frame_cnt", a_frame, 2);
        chk("t1_err_cnt", a_err, 0);
        chk("t1_done_pass", {a_done, a_pass}, 2'b11);
        chk("t1_readies_after_done", {a_dr, a_rr}, 0);
        a_set(1'b0, 8'h00, 8'h00, 1'b0);

        // Data error on beat 2 halts the checker.
        a_reset();
        a_fire = 1'b1; @(negedge clk); a_fire = 1'b0;
        a_set(1'b1, 8'h00, 8'h00, 1'b0); qa.push_back({32'd1, 32'd0, 32'd0}); @(negedge clk);
        a_set(1'b1, 8'h01, 8'h01, 1'b0); qa.push_back({32'd2, 32'd0, 32'd0}); @(negedge clk);
        a_set(1'b1, 8'hA5, 8'h5A, 1'b0); qa.push_back({32'd3, 32'd1, 32'd0}); @(negedge clk);
        a_set(1'b1, 8'h03, 8'h03, 1'b1);
        chk("t2_halted", a_halt, 1);
        chk("t2_readies", {a_dr, a_rr}, 0);
        chk("t2_first_err_idx", a_fidx, 2);
        chk("t2_first_err_got", a_fgot, 8'hA5);
        chk("t2_first_err_exp", a_fexp, 8'h5A);
        chk("t2_latency_min", a_lat, 1);
        @(negedge clk);
        chk("t2_beat_cnt_frozen", a_beat, 3);
        chk("t2_err_cnt", a_err, 1);
        chk("t2_done_pass", {a_done, a_pass}, 0);

        // Reset at beat 2, then a fresh run with latency 3.
        a_reset();
        a_fire = 1'b1; @(negedge clk); a_fire = 1'b0;
        a_set(1'b1, 8'h00, 8'h00, 1'b0); qa.push_back({32'd1, 32'd0, 32'd0}); @(negedge clk);
        a_set(1'b1, 8'h01, 8'h01, 1'b0); qa.push_back({32'd2, 32'd0, 32'd0}); @(negedge clk);
        a_set(1'b1, 8'h02, 8'h02, 1'b0);
        a_reset();
        a_fire = 1'b1; @(negedge clk); a_fire = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            a_set(1'b1, 8'(i + 16), 8'(i + 16), (i % 4) == 3);
            qa.push_back({32'(i + 1), 32'd0, 32'd0});
            @(negedge clk);
        end
        chk("t5_latency", a_lat, 3);
        chk("t5_beat_cnt", a_beat, 8);
        chk("t5_done_pass", {a_done, a_pass}, 2'b11);
        a_set(1'b0, 8'h00, 8'h00, 1'b0);

        // Latency saturates at 15; a second stim_fire in MEASURE is ignored.
        a_reset();
        a_fire = 1'b1; @(negedge clk);
        for (int c = 1; c < 20; c++) begin
            a_fire = (c == 7);
            @(negedge clk);
        end
        a_fire = 1'b0;
        a_set(1'b1, 8'h3C, 8'h3C, 1'b0); qa.push_back({32'd1, 32'd0, 32'd0}); @(negedge clk);
        chk("t6_latency_sat", a_lat, 15);
        chk("t6_latency_valid", a_latv, 1);
        a_set(1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic b_reset();
        b_dv = 1'b0; b_rv = 1'b0; b_dl = 1'b0; b_fire = 1'b0; rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        chk("b_rst_beat_cnt", b_beat, 0);
        chk("b_rst_err_cnt", b_err, 0);
        chk("b_rst_flags", {b_latv, b_halt, b_done, b_pass}, 0);
    endtask

    task automatic b_run(input bit tl_fault, input bit with_gap, output int unsigned lat_exp);
        bit ok;
        logic l;
        int unsigned ec;
        lat_exp = 0;
        b_fire = 1'b1; @(negedge clk); b_fire = 1'b0; b_gchk = 1'b1;
        for (int i = 0; i < 1000 && !b_abort; i++) begin
            if (with_gap && i == 500) begin
                b_dv = 1'b1; b_rv = 1'b0;
                repeat (10) begin
                    @(posedge clk);
                    chk("b_gap_dut_ready", b_dr, 0);
                    @(negedge clk);
                end
            end
            l  = tl_fault ? ((((i % 4) == 3) && i != 3) || i == 5) : ((i % 4) == 3);
            ec = !tl_fault ? 0 : (i < 3) ? 0 : (i < 5) ? 1 : 2;
            b_dd = 8'(i); b_rd = 8'(i); b_dl = l; b_dv = 1'b1; b_rv = 1'b1;
            qb.push_back({32'(i + 1), 32'(ec), 32'(ec)});
            ok = 1'b0;
            for (int t = 1; t <= 64 && !ok; t++) begin
                @(posedge clk);
                ok = b_dv && b_dr;
                @(negedge clk);
                if (ok && i == 0) lat_exp = 32'(t);
            end
            if (!ok) begin
                fail_note("b_handshake_timeout");
                b_abort = 1'b1;
            end
        end
        b_gchk = 1'b0;
    endtask

    task automatic b_tests();
        int unsigned lat;
        // tlast missing on beat 3 and extra on beat 5; checking continues to done.
        b_reset();
        b_run(1'b1, 1'b0, lat);
        chk("t3_done", b_done, 1);
        chk("t3_pass", b_pass, 0);
        chk("t3_halted", b_halt, 0);
        chk("t3_beat_cnt", b_beat, 1000);
        chk("t3_frame_cnt", b_frame, 250);
        chk("t3_tlast_err_cnt", b_tlerr, 2);
        chk("t3_err_cnt", b_err, 2);
        chk("t3_first_err_idx", b_fidx, 3);
        chk("t3_first_err_data", {b_fgot, b_fexp}, 16'h0303);
        chk("t3_latency", b_lat, lat);
        chk("t3_readies_after_done", {b_dr, b_rr}, 0);

        // Clean 1000-beat throttled run with a 10-cycle gap on the expected stream.
        b_reset();
        b_run(1'b0, 1'b1, lat);
        chk("t4_done_pass", {b_done, b_pass}, 2'b11);
        chk("t4_beat_cnt", b_beat, 1000);
        chk("t4_frame_cnt", b_frame, 250);
        chk("t4_err_cnt", b_err, 0);
        chk("t4_latency", b_lat, lat);
        chk("t4_latency_valid", b_latv, 1);
        b_dv = 1'b0; b_rv = 1'b0;
    endtask

    initial begin
        #600000;
        fail_note("watchdog_timeout");
        $fatal(1, "bench did not finish in time");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; a_fire = 1'b0; b_fire = 1'b0;
        a_set(1'b0, 8'h00, 8'h00, 1'b0);
        b_dv = 1'b0; b_rv = 1'b0; b_dl = 1'b0; b_dd = 8'h00; b_rd = 8'h00;
        repeat (2) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        a_tests();
        b_tests();
        repeat (2) @(negedge clk);
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/ccsds_axis_stream_checker.md
# ccsds_axis_stream_checker

Synthesizable AXI-Stream self-checker for the CCSDS-LDPC encoder/decoder chain. It consumes the DUT output stream and an expected-data stream in lockstep and applies optional pseudo-random backpressure to both. It counts data and frame-boundary (tlast) mismatches and measures first-output latency. It replaces file-based comparison so regression can run on hardware or in long simulations, and it is generic in width, frame length, frame count and stop mode.

## Interface
Parameters:
- WIDTH, 8, tdata width of both streams.
- FRAME_LEN, 1020, beats per frame (8160 bits / 8); legal range ≥1.
- NUM_FRAMES, 0, frames to check before DONE; 0 = unlimited.
- STOP_ON_ERR, 1, 1 = halt on the first error; 0 = count errors and continue.
- READY_MODE, 0, 0 = ready gate always 1; 1 = LFSR-throttled ready gate.
- LAT_W, 16, latency counter width.
- CNT_W, 32, beat, error and frame counter width.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stim_fire  in  1  one-cycle pulse when the first stimulus beat is accepted by the DUT.
- s_dut_tdata  in  WIDTH  DUT output data.
- s_dut_tvalid  in  1  DUT output valid.
- s_dut_tlast  in  1  DUT frame end.
- s_dut_tready  out  1  ready to DUT.
- s_ref_tdata  in  WIDTH  expected data.
- s_ref_tvalid  in  1  expected data valid.
- s_ref_tready  out  1  ready to expected source.
- beat_cnt  out  CNT_W  compared beats.
- frame_cnt  out  CNT_W  completed frames.
- err_cnt  out  CNT_W  total errors (data + tlast), saturating.
- tlast_err_cnt  out  CNT_W  tlast errors, saturating.
- first_err_idx  out  CNT_W  beat_cnt value at the first error.
- first_err_got, first_err_exp  out  WIDTH  DUT and expected data at the first error.
- latency  out  LAT_W  cycles from stim_fire to the first compare; saturating.
- latency_valid  out  1  latency latched.
- halted  out  1  stopped on error.
- done  out  1  NUM_FRAMES completed.
- pass  out  1  done && err_cnt==0.

## Operation
- States:
  - IDLE → MEASURE on stim_fire.
  - MEASURE → RUN on the first compare.
  - RUN → HALT on an error when STOP_ON_ERR=1.
  - RUN → DONE when frame_cnt reaches NUM_FRAMES (NUM_FRAMES≠0).
  - HALT and DONE are left only by rst.
  - stim_fire outside IDLE is ignored.
- gate = 1 when READY_MODE=0. When READY_MODE=1, gate = lfsr[0]|lfsr[1]:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1.
  - Advances every cycle rst is low.
- Ready outputs:
  - s_dut_tready = gate & s_ref_tvalid & (state∈{MEASURE,RUN}).
  - s_ref_tready = gate & s_dut_tvalid & (same states).
  - Both streams therefore transfer in the same cycle (compare cycle); a compare is never one-sided.
- Each compare:
  - beat_cnt +1.
  - Data error if s_dut_tdata≠s_ref_tdata.
  - Expected tlast = (beat_in_frame==FRAME_LEN-1). beat_in_frame wraps to 0 after FRAME_LEN-1, and frame_cnt increments at the wrap.
  - tlast error if s_dut_tlast≠expected tlast (missing or extra).
  - A beat with both a data and a tlast error adds 1 to err_cnt and 1 to tlast_err_cnt.
- First error latches first_err_idx (pre-increment beat_cnt), first_err_got and first_err_exp. These never update again until rst.
- Latency counter:
  - Clears to 0 in the stim_fire cycle and increments each cycle in MEASURE.
  - On the first compare, latency = counter+1 and latency_valid = 1.
  - Saturates at 2^LAT_W−1; minimum value is 1.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset:
  - Every output is 0 the cycle after rst is sampled high: readies 0, counters 0, latency_valid/halted/done/pass 0.
  - State goes to IDLE and the LFSR reloads its seed.
  - Reset mid-frame discards the partial frame.
- Readies are combinational from the valids, gate and state. Everything else is registered; counters and flags update on the edge ending the compare cycle.
- Error in compare cycle N with STOP_ON_ERR=1: halted=1 and both readies 0 from cycle N+1.
- Final beat of frame NUM_FRAMES: done=1 and readies 0 from the next cycle. pass is valid in the same cycle as done.
- A stim_fire pulse in the reset cycle is ignored.

## Test plan
- FRAME_LEN=4, NUM_FRAMES=2, READY_MODE=0. Both streams carry 0x00..0x07, tlast on beats 3 and 7. stim_fire at cycle 0, first valid at cycle 5 → latency=5, latency_valid=1, beat_cnt=8, frame_cnt=2, err_cnt=0, done=1, pass=1.
- STOP_ON_ERR=1. Beat 2 has DUT 0xA5, expected 0x5A → first_err_idx=2, got=0xA5, exp=0x5A, err_cnt=1. halted=1 and readies 0 the next cycle; beat_cnt stays 3.
- STOP_ON_ERR=0, FRAME_LEN=4. DUT omits tlast on beat 3 and asserts it on beat 5 → tlast_err_cnt=2, err_cnt=2, first_err_idx=3, checking continues, pass=0 at done.
- READY_MODE=1, 1000 beats with identical data. Readies match the LFSR gate cycle by cycle; while s_ref_tvalid is held low for 10 cycles, s_dut_tready=0 → beat_cnt=1000, err_cnt=0, no lost or duplicated beats.
- rst asserted at beat 2 of frame 0 → all outputs 0 next cycle. A new stim_fire plus a full run gives a fresh latency and pass=1.
- LAT_W=4, first compare 20 cycles after stim_fire → latency=15 (saturated). A stim_fire pulse during MEASURE does not restart the count.
